// File: rtl/ir_pkg.sv
// ir_pkg -- shared definitions for the NEC IR transmit sequencer.
//   SFR window addresses of the IR transmitter, CTRL register bit positions,
//   the sequencer FSM state type, and a helper that decodes the SFR bus
//   drive for a given state.
package ir_pkg;

    // SFR window of the NEC IR transmitter
    localparam logic [7:0] SFR_CTRL   = 8'hF1;
    localparam logic [7:0] SFR_BYTE_1 = 8'hF2;
    localparam logic [7:0] SFR_BYTE_2 = 8'hF3;
    localparam logic [7:0] SFR_BYTE_3 = 8'hF4;
    localparam logic [7:0] SFR_BYTE_4 = 8'hF5;

    // CTRL register bit positions
    localparam int unsigned CTRL_SEND   = 0;
    localparam int unsigned CTRL_REPEAT = 1;
    localparam int unsigned CTRL_DONE   = 4;

    localparam logic [7:0] CTRL_SEND_MASK   = 8'(1) << CTRL_SEND;
    localparam logic [7:0] CTRL_REPEAT_MASK = 8'(1) << CTRL_REPEAT;
    localparam logic [7:0] CTRL_DONE_MASK   = 8'(1) << CTRL_DONE;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_AN,
        WR_C,
        WR_CN,
        WR_GO,
        POLL,
        CLR,
        GAP,
        WR_REP
    } ir_state_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } sfr_bus_t;

    // Bus drive while sitting in state st; address/data are 0 when idle.
    function automatic sfr_bus_t sfr_bus_for(input ir_state_t  st,
                                             input logic [7:0] dev_addr,
                                             input logic [7:0] cmd);
        sfr_bus_t b;
        b = '0;
        case (st)
            WR_A:   begin b.wr = 1'b1; b.addr = SFR_BYTE_1; b.data = dev_addr;         end
            WR_AN:  begin b.wr = 1'b1; b.addr = SFR_BYTE_2; b.data = ~dev_addr;        end
            WR_C:   begin b.wr = 1'b1; b.addr = SFR_BYTE_3; b.data = cmd;              end
            WR_CN:  begin b.wr = 1'b1; b.addr = SFR_BYTE_4; b.data = ~cmd;             end
            WR_GO:  begin b.wr = 1'b1; b.addr = SFR_CTRL;   b.data = CTRL_SEND_MASK;   end
            POLL:   begin b.rd = 1'b1; b.addr = SFR_CTRL;                              end
            CLR:    begin b.wr = 1'b1; b.addr = SFR_CTRL;   b.data = '0;               end
            WR_REP: begin b.wr = 1'b1; b.addr = SFR_CTRL;   b.data = CTRL_REPEAT_MASK; end
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- round-robin grant among NUM_REQ level requests.
//   clk, reset_n   : clock, asynchronous active-low reset
//   req            : request per requester
//   accept         : consumer takes the current grant; pointer moves past it
//   grant_valid    : some request is pending (combinational)
//   grant_idx      : first requester at or above the pointer, wrapping
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic               grant_valid,
    output logic [2:0]         grant_idx
);

    logic [2:0] ptr;
    logic [7:0] req_ext;
    logic [3:0] cand;

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req;
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(NUM_REQ))
                cand = cand - 4'(NUM_REQ);
            if (!grant_valid && req_ext[cand[2:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

endmodule

// File: rtl/ir_tx_sequencer.sv
// ir_tx_sequencer -- autonomous SFR master for the NEC IR transmitter.
//   Grants one held key round-robin, writes address/~address/command/~command
//   into F2..F5, starts the frame via CTRL (F1), polls the DONE flag, clears
//   it, and sends repeat codes every FRAME_CYCLES while the key stays held.
//   clk, reset_n        : clock, asynchronous active-low reset
//   req, cmd            : per-key hold level and command byte
//   sfr_rd/sfr_wr       : SFR strobes (never both high)
//   sfr_addr/data_out   : SFR address / write data, 0 when bus idle
//   sfr_data_in         : SFR read data, combinational with sfr_rd
//   busy                : FSM not in IDLE
//   active_id           : last granted key
//   frame_done          : pulse when DONE observed
//   timeout_err         : sticky poll timeout flag
module ir_tx_sequencer
    import ir_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter logic [7:0]  DEV_ADDR       = 8'h00,
    parameter int unsigned FRAME_CYCLES   = 5_400_000,
    parameter int unsigned TIMEOUT_CYCLES = 7_500_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] cmd,
    output logic                 sfr_rd,
    output logic                 sfr_wr,
    output logic [7:0]           sfr_addr,
    output logic [7:0]           sfr_data_out,
    input  logic [7:0]           sfr_data_in,
    output logic                 busy,
    output logic [2:0]           active_id,
    output logic                 frame_done,
    output logic                 timeout_err
);

    localparam logic [31:0] FRAME_LAST   = 32'(FRAME_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    ir_state_t   state, nxt;
    sfr_bus_t    bus_nxt;
    logic [31:0] frame_cnt;
    logic [31:0] poll_cnt;
    logic [7:0]  cmd_lat;
    logic [7:0]  cmd_sel;
    logic [7:0]  req_ext;
    logic        clr_to_idle;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic        accept;
    logic        done_seen;
    logic        poll_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign accept = (state == IDLE) && grant_valid;

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req;
    end

    always_comb begin
        cmd_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (grant_idx == 3'(i))
                cmd_sel = cmd[8*i +: 8];
    end

    always_comb begin
        nxt          = state;
        done_seen    = 1'b0;
        poll_expired = 1'b0;
        case (state)
            IDLE:   if (grant_valid) nxt = WR_A;
            WR_A:   nxt = WR_AN;
            WR_AN:  nxt = WR_C;
            WR_C:   nxt = WR_CN;
            WR_CN:  nxt = WR_GO;
            WR_GO:  nxt = POLL;
            POLL: begin
                if (|(sfr_data_in & CTRL_DONE_MASK)) begin
                    done_seen = 1'b1;
                    nxt       = CLR;
                end else if (poll_cnt == TIMEOUT_LAST) begin
                    poll_expired = 1'b1;
                    nxt          = CLR;
                end
            end
            CLR:    nxt = clr_to_idle ? IDLE : GAP;
            // Key level is looked at only on the cycle the frame period ends.
            GAP:    if (frame_cnt == FRAME_LAST)
                        nxt = req_ext[active_id] ? WR_REP : IDLE;
            WR_REP: nxt = POLL;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign bus_nxt = sfr_bus_for(nxt, DEV_ADDR, cmd_lat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sfr_rd       <= 1'b0;
            sfr_wr       <= 1'b0;
            sfr_addr     <= '0;
            sfr_data_out <= '0;
            busy         <= 1'b0;
            active_id    <= '0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
            frame_cnt    <= '0;
            poll_cnt     <= '0;
            cmd_lat      <= '0;
            clr_to_idle  <= 1'b0;
        end else begin
            state        <= nxt;
            sfr_rd       <= bus_nxt.rd;
            sfr_wr       <= bus_nxt.wr;
            sfr_addr     <= bus_nxt.addr;
            sfr_data_out <= bus_nxt.data;
            busy         <= (nxt != IDLE);
            frame_done   <= done_seen;
            if (poll_expired)
                timeout_err <= 1'b1;
            if (accept) begin
                active_id <= grant_idx;
                cmd_lat   <= cmd_sel;
            end
            if (state == POLL) begin
                poll_cnt    <= poll_cnt + 32'd1;
                clr_to_idle <= poll_expired;
            end else begin
                poll_cnt <= '0;
            end
            // Counter reads 0 during the WR_GO / WR_REP cycle itself.
            if (nxt == WR_GO || nxt == WR_REP)
                frame_cnt <= '0;
            else if (frame_cnt != FRAME_LAST)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ir_tx_sequencer.sv
// tb_ir_tx_sequencer -- self-checking bench for ir_tx_sequencer.
//   Behavioural SFR responder sets DONE 200 cycles after a CTRL send/repeat
//   write. A monitor logs every SFR write with its cycle number; expected
//   frame contents, repeat times and grant order come from the protocol rules.
module tb_ir_tx_sequencer;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned FRAME = 1000;
    localparam int unsigned TMO   = 500;
    localparam logic [7:0]  DEV   = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] cmd;
    logic        sfr_rd, sfr_wr;
    logic [7:0]  sfr_addr, sfr_data_out, sfr_data_in;
    logic        busy;
    logic [2:0]  active_id;
    logic        frame_done, timeout_err;

    ir_tx_sequencer #(
        .NUM_REQ        (NREQ),
        .DEV_ADDR       (DEV),
        .FRAME_CYCLES   (FRAME),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .cmd          (cmd),
        .sfr_rd       (sfr_rd),
        .sfr_wr       (sfr_wr),
        .sfr_addr     (sfr_addr),
        .sfr_data_out (sfr_data_out),
        .sfr_data_in  (sfr_data_in),
        .busy         (busy),
        .active_id    (active_id),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SFR responder
    logic [7:0] ctrl;
    int         dcnt;
    bit         no_done = 1'b0;
    assign sfr_data_in = ctrl;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= 8'h00;
            dcnt <= 0;
        end else if (sfr_wr && sfr_addr == 8'hF1) begin
            ctrl <= sfr_data_out;
            dcnt <= (sfr_data_out[1:0] != 2'b00) ? 200 : 0;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !no_done) ctrl[4] <= 1'b1;
        end
    end

    // Bus monitor
    typedef struct {
        int unsigned cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } wr_t;

    wr_t wlog[$];
    int  done_cnt = 0;
    int  rd_cnt   = 0;
    int  rd_bad   = 0;
    int  idle_bad = 0;
    int  both_bad = 0;

    always @(negedge clk) begin
        if (sfr_wr) wlog.push_back('{cyc, sfr_addr, sfr_data_out});
        if (sfr_rd) begin
            rd_cnt++;
            if (sfr_addr != 8'hF1) rd_bad++;
        end
        if (sfr_rd && sfr_wr) both_bad++;
        if (!sfr_rd && !sfr_wr && (sfr_addr != 8'h00 || sfr_data_out != 8'h00)) idle_bad++;
        if (frame_done) done_cnt++;
    end

    // Reference helpers
    int mptr = 0;

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++)
            if (m[(p + i) % 4]) return (p + i) % 4;
        return 0;
    endfunction

    function automatic int find_nth(input logic [7:0] a, input logic [7:0] d, input int n);
        int c = 0;
        foreach (wlog[i])
            if (wlog[i].addr == a && wlog[i].data == d) begin
                c++;
                if (c == n) return i;
            end
        return -1;
    endfunction

    function automatic int count_wr(input logic [7:0] a, input logic [7:0] d);
        int c = 0;
        foreach (wlog[i])
            if (wlog[i].addr == a && wlog[i].data == d) c++;
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0;
        rd_cnt   = 0;
    endtask

    task automatic wait_idle(input int budget, input string tag, output int unsigned idle_cyc);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        idle_cyc = cyc;
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_frame(input int b, input logic [7:0] c, input string tag, output int unsigned t);
        logic [7:0] ea[5];
        logic [7:0] ed[5];
        ea = '{8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF1};
        ed = '{DEV, ~DEV, c, ~c, 8'h01};
        t = 0;
        check_eq({tag, "_frame_len"}, wlog.size() >= b + 5, 1);
        if (wlog.size() >= b + 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq({tag, "_addr"}, wlog[b+i].addr, ea[i]);
                check_eq({tag, "_data"}, wlog[b+i].data, ed[i]);
                if (i > 0) check_eq({tag, "_consec"}, wlog[b+i].cyc - wlog[b+i-1].cyc, 1);
            end
            t = wlog[b+4].cyc;
        end
    endtask

    // One key pressed alone for 'hold' cycles.
    task automatic run_single(input string tag, input int k, input logic [7:0] c,
                              input int hold, input logic exp_te);
        int unsigned drop_cyc, t0, tl, ic;
        int nrep, idx;
        clear_log();
        cmd = $urandom();
        cmd[8*k +: 8] = c;
        req[k] = 1'b1;
        repeat (hold) tick();
        req[k] = 1'b0;
        drop_cyc = cyc;
        wait_idle(3000, tag, ic);
        check_frame(0, c, tag, t0);
        // repeat j happens iff key still held at the end of period j
        nrep = 0;
        while (t0 + FRAME * (nrep + 1) <= drop_cyc) nrep++;
        for (int j = 1; j <= nrep; j++) begin
            idx = find_nth(8'hF1, 8'h02, j);
            check_eq({tag, "_rep_found"}, idx >= 0, 1);
            if (idx >= 0) check_eq({tag, "_rep_cyc"}, wlog[idx].cyc, t0 + FRAME * j);
        end
        check_eq({tag, "_nrep"}, count_wr(8'hF1, 8'h02), nrep);
        check_eq({tag, "_done_pulses"}, done_cnt, nrep + 1);
        check_eq({tag, "_clr_writes"}, count_wr(8'hF1, 8'h00), nrep + 1);
        check_eq({tag, "_writes"}, wlog.size(), 6 + 2 * nrep);
        check_eq({tag, "_active_id"}, active_id, k);
        check_eq({tag, "_timeout_err"}, timeout_err, exp_te);
        tl = t0 + FRAME * nrep;
        check_eq({tag, "_idle_at"}, (ic >= tl + FRAME - 1) && (ic <= tl + FRAME + 1), 1);
        mptr = (k + 1) % 4;
    endtask

    // Two keys held together; the first is released after its first frame.
    task automatic run_pair(input logic [3:0] mask, input string tag);
        int g1, g2, n, i2;
        logic [3:0] rest;
        int unsigned t1, t2, ic;
        g1 = rr_pick(mask, mptr);
        rest = mask;
        rest[g1] = 1'b0;
        g2 = rr_pick(rest, (g1 + 1) % 4);
        clear_log();
        cmd = $urandom();
        req = mask;
        n = 0;
        while (done_cnt < 1 && n < 2000) begin tick(); n++; end
        check_eq({tag, "_first_id"}, active_id, g1);
        req[g1] = 1'b0;
        n = 0;
        while (count_wr(8'hF1, 8'h01) < 2 && n < 3000) begin tick(); n++; end
        n = 0;
        while (done_cnt < 2 && n < 1000) begin tick(); n++; end
        req = 4'b0000;
        wait_idle(3000, tag, ic);
        check_frame(0, cmd[8*g1 +: 8], {tag, "_f1"}, t1);
        i2 = find_nth(8'hF1, 8'h01, 2);
        check_eq({tag, "_second_found"}, i2 >= 4, 1);
        if (i2 >= 4) begin
            check_frame(i2 - 4, cmd[8*g2 +: 8], {tag, "_f2"}, t2);
            check_eq({tag, "_spacing"}, t2 - t1 >= FRAME, 1);
        end
        check_eq({tag, "_second_id"}, active_id, g2);
        check_eq({tag, "_no_repeat"}, count_wr(8'hF1, 8'h02), 0);
        mptr = (g2 + 1) % 4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned t0, ic, dummy;
        int k, n, a, b, hold;
        logic [3:0] m;

        reset_n = 1'b0;
        req     = 4'b0000;
        cmd     = '0;
        repeat (3) tick();
        check_eq("reset_outputs",
                 {sfr_rd, sfr_wr, sfr_addr, sfr_data_out, busy, active_id, frame_done, timeout_err}, 0);
        reset_n = 1'b1;
        repeat (3) tick();
        check_eq("reset_busy", busy, 0);

        // single short press, key 2, cmd 0x45
        run_single("single", 2, 8'h45, 10, 1'b0);

        // pointer at 3: wrap gives 3 then 0
        run_pair(4'b1001, "wrap");

        // held key with repeats
        run_single("held", 0, 8'($urandom()), 3500, 1'b0);
        k = $urandom_range(0, 3);
        n = $urandom_range(1, 2);
        hold = 1000 * n + $urandom_range(100, 900);
        run_single("held_rand", k, 8'($urandom()), hold, 1'b0);

        // random two-key contention
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        m = 4'b0000;
        m[a] = 1'b1;
        m[b] = 1'b1;
        run_pair(m, "pair_rand");

        // poll timeout
        no_done = 1'b1;
        clear_log();
        k = $urandom_range(0, 3);
        cmd = $urandom();
        req[k] = 1'b1;
        repeat (10) tick();
        req[k] = 1'b0;
        wait_idle(2000, "tmo", ic);
        check_frame(0, cmd[8*k +: 8], "tmo", t0);
        check_eq("tmo_writes", wlog.size(), 6);
        if (wlog.size() == 6) begin
            check_eq("tmo_clr_addr", wlog[5].addr, 8'hF1);
            check_eq("tmo_clr_data", wlog[5].data, 8'h00);
            check_eq("tmo_clr_cyc", wlog[5].cyc, t0 + TMO + 1);
        end
        check_eq("tmo_poll_reads", rd_cnt, TMO);
        check_eq("tmo_err", timeout_err, 1);
        check_eq("tmo_no_done", done_cnt, 0);
        no_done = 1'b0;
        mptr = (k + 1) % 4;

        // timeout_err stays set through a good frame
        run_single("sticky", $urandom_range(0, 3), 8'($urandom()), 10, 1'b1);

        // reset during WR_C
        clear_log();
        k = $urandom_range(0, 3);
        cmd = $urandom();
        req[k] = 1'b1;
        n = 0;
        while (!(sfr_wr && sfr_addr == 8'hF4) && n < 50) begin tick(); n++; end
        check_eq("rst_saw_wrc", sfr_wr && sfr_addr == 8'hF4, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_outputs",
                 {sfr_rd, sfr_wr, sfr_addr, sfr_data_out, busy, active_id, frame_done, timeout_err}, 0);
        req = 4'b0000;
        repeat (3) tick();
        reset_n = 1'b1;
        clear_log();
        repeat (300) tick();
        check_eq("rst_no_writes", wlog.size(), 0);
        check_eq("rst_no_reads", rd_cnt, 0);
        check_eq("rst_busy", busy, 0);
        mptr = 0;

        // pointer back at 0: key 0 then key 3
        run_pair(4'b1001, "after_rst");

        check_eq("bus_idle_zero", idle_bad, 0);
        check_eq("rd_wr_exclusive", both_bad, 0);
        check_eq("poll_addr", rd_bad, 0);

        dummy = ic;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
